// File: rtl/tl_buffer_ad_if.sv
// TileLink-UL A/D channel bundle seen by tl_buffer_ad: the "in" side faces the
// crossbar (client), the "out" side faces the 64-bit width widget (manager).
interface tl_buffer_ad_if;
  // A channel, client side (enqueue)
  logic        auto_in_a_valid;
  logic        auto_in_a_ready;
  logic [2:0]  auto_in_a_bits_opcode;
  logic [2:0]  auto_in_a_bits_param;
  logic [2:0]  auto_in_a_bits_size;
  logic [7:0]  auto_in_a_bits_source;
  logic [30:0] auto_in_a_bits_address;
  logic [7:0]  auto_in_a_bits_mask;
  logic [63:0] auto_in_a_bits_data;
  logic        auto_in_a_bits_corrupt;

  // A channel, widget side (dequeue)
  logic        auto_out_a_valid;
  logic        auto_out_a_ready;
  logic [2:0]  auto_out_a_bits_opcode;
  logic [2:0]  auto_out_a_bits_param;
  logic [2:0]  auto_out_a_bits_size;
  logic [7:0]  auto_out_a_bits_source;
  logic [30:0] auto_out_a_bits_address;
  logic [7:0]  auto_out_a_bits_mask;
  logic [63:0] auto_out_a_bits_data;
  logic        auto_out_a_bits_corrupt;

  // D channel, widget side (enqueue)
  logic        auto_out_d_valid;
  logic        auto_out_d_ready;
  logic [2:0]  auto_out_d_bits_opcode;
  logic [1:0]  auto_out_d_bits_param;
  logic [2:0]  auto_out_d_bits_size;
  logic [7:0]  auto_out_d_bits_source;
  logic        auto_out_d_bits_sink;
  logic        auto_out_d_bits_denied;
  logic [63:0] auto_out_d_bits_data;
  logic        auto_out_d_bits_corrupt;

  // D channel, client side (dequeue)
  logic        auto_in_d_valid;
  logic        auto_in_d_ready;
  logic [2:0]  auto_in_d_bits_opcode;
  logic [1:0]  auto_in_d_bits_param;
  logic [2:0]  auto_in_d_bits_size;
  logic [7:0]  auto_in_d_bits_source;
  logic        auto_in_d_bits_sink;
  logic        auto_in_d_bits_denied;
  logic [63:0] auto_in_d_bits_data;
  logic        auto_in_d_bits_corrupt;

  // The buffer itself
  modport slave (
    input  auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_param,
           auto_in_a_bits_size, auto_in_a_bits_source, auto_in_a_bits_address,
           auto_in_a_bits_mask, auto_in_a_bits_data, auto_in_a_bits_corrupt,
    output auto_in_a_ready,
    output auto_out_a_valid, auto_out_a_bits_opcode, auto_out_a_bits_param,
           auto_out_a_bits_size, auto_out_a_bits_source, auto_out_a_bits_address,
           auto_out_a_bits_mask, auto_out_a_bits_data, auto_out_a_bits_corrupt,
    input  auto_out_a_ready,
    input  auto_out_d_valid, auto_out_d_bits_opcode, auto_out_d_bits_param,
           auto_out_d_bits_size, auto_out_d_bits_source, auto_out_d_bits_sink,
           auto_out_d_bits_denied, auto_out_d_bits_data, auto_out_d_bits_corrupt,
    output auto_out_d_ready,
    output auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_param,
           auto_in_d_bits_size, auto_in_d_bits_source, auto_in_d_bits_sink,
           auto_in_d_bits_denied, auto_in_d_bits_data, auto_in_d_bits_corrupt,
    input  auto_in_d_ready
  );

  // The environment around the buffer (client + widget together)
  modport master (
    output auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_param,
           auto_in_a_bits_size, auto_in_a_bits_source, auto_in_a_bits_address,
           auto_in_a_bits_mask, auto_in_a_bits_data, auto_in_a_bits_corrupt,
    input  auto_in_a_ready,
    input  auto_out_a_valid, auto_out_a_bits_opcode, auto_out_a_bits_param,
           auto_out_a_bits_size, auto_out_a_bits_source, auto_out_a_bits_address,
           auto_out_a_bits_mask, auto_out_a_bits_data, auto_out_a_bits_corrupt,
    output auto_out_a_ready,
    output auto_out_d_valid, auto_out_d_bits_opcode, auto_out_d_bits_param,
           auto_out_d_bits_size, auto_out_d_bits_source, auto_out_d_bits_sink,
           auto_out_d_bits_denied, auto_out_d_bits_data, auto_out_d_bits_corrupt,
    input  auto_out_d_ready,
    input  auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_param,
           auto_in_d_bits_size, auto_in_d_bits_source, auto_in_d_bits_sink,
           auto_in_d_bits_denied, auto_in_d_bits_data, auto_in_d_bits_corrupt,
    output auto_in_d_ready
  );
endinterface

// File: rtl/tl_buffer_ad.sv
// Two independent registered FIFOs (A requests, D responses) that cut the
// valid/ready and payload paths between the crossbar and the width widget.
module tl_buffer_ad_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_bits,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_bits
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head_reg, head_next;
  logic [PW-1:0]    tail_reg, tail_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             enq_fire, deq_fire;

  // Handshakes depend on registered occupancy only; no flow-through path.
  assign enq_ready = (count_reg != FULL);
  assign deq_valid = (count_reg != '0);
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_valid && deq_ready;
  assign deq_bits  = mem[head_reg];

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    // Explicit wrap so non-power-of-two depths never index past the array.
    if (deq_fire) head_next = (head_reg == LAST) ? '0 : head_reg + PW'(1);
    if (enq_fire) tail_next = (tail_reg == LAST) ? '0 : tail_reg + PW'(1);
    case ({enq_fire, deq_fire})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Storage is deliberately left out of reset; occupancy alone gates visibility.
  always_ff @(posedge clock) begin
    if (enq_fire) mem[tail_reg] <= enq_bits;
  end
endmodule

module tl_buffer_ad #(
  parameter int A_DEPTH = 2,
  parameter int D_DEPTH = 2
) (
  input logic           clock,
  input logic           reset,
  tl_buffer_ad_if.slave bus
);
  localparam int A_W = 3 + 3 + 3 + 8 + 31 + 8 + 64 + 1;
  localparam int D_W = 3 + 2 + 3 + 8 + 1 + 1 + 1 + 64;

  logic [A_W-1:0] a_enq_bits, a_deq_bits;
  logic [D_W-1:0] d_enq_bits, d_deq_bits;

  assign a_enq_bits = {bus.auto_in_a_bits_opcode, bus.auto_in_a_bits_param,
                       bus.auto_in_a_bits_size, bus.auto_in_a_bits_source,
                       bus.auto_in_a_bits_address, bus.auto_in_a_bits_mask,
                       bus.auto_in_a_bits_data, bus.auto_in_a_bits_corrupt};

  assign {bus.auto_out_a_bits_opcode, bus.auto_out_a_bits_param,
          bus.auto_out_a_bits_size, bus.auto_out_a_bits_source,
          bus.auto_out_a_bits_address, bus.auto_out_a_bits_mask,
          bus.auto_out_a_bits_data, bus.auto_out_a_bits_corrupt} = a_deq_bits;

  assign d_enq_bits = {bus.auto_out_d_bits_opcode, bus.auto_out_d_bits_param,
                       bus.auto_out_d_bits_size, bus.auto_out_d_bits_source,
                       bus.auto_out_d_bits_sink, bus.auto_out_d_bits_denied,
                       bus.auto_out_d_bits_corrupt, bus.auto_out_d_bits_data};

  assign {bus.auto_in_d_bits_opcode, bus.auto_in_d_bits_param,
          bus.auto_in_d_bits_size, bus.auto_in_d_bits_source,
          bus.auto_in_d_bits_sink, bus.auto_in_d_bits_denied,
          bus.auto_in_d_bits_corrupt, bus.auto_in_d_bits_data} = d_deq_bits;

  tl_buffer_ad_fifo #(.WIDTH(A_W), .DEPTH(A_DEPTH)) a_fifo (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (bus.auto_in_a_valid),
    .enq_ready (bus.auto_in_a_ready),
    .enq_bits  (a_enq_bits),
    .deq_valid (bus.auto_out_a_valid),
    .deq_ready (bus.auto_out_a_ready),
    .deq_bits  (a_deq_bits)
  );

  tl_buffer_ad_fifo #(.WIDTH(D_W), .DEPTH(D_DEPTH)) d_fifo (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (bus.auto_out_d_valid),
    .enq_ready (bus.auto_out_d_ready),
    .enq_bits  (d_enq_bits),
    .deq_valid (bus.auto_in_d_valid),
    .deq_ready (bus.auto_in_d_ready),
    .deq_bits  (d_deq_bits)
  );
endmodule
